// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader writing 24-bit words into instruction memory.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_BITS = 4,
    parameter int WORD_WIDTH = 24,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] COUNT = 3'd1;
    localparam logic [2:0] B0    = 3'd2;
    localparam logic [2:0] B1    = 3'd3;
    localparam logic [2:0] B2    = 3'd4;
    localparam logic [2:0] WRITE = 3'd5;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] CHECK = 3'd6;
    logic [7:0] csum;
`endif

    logic [2:0]         state;
    logic [ADDR_BITS:0] count;
    logic               take;
    logic               last;

    assign rx_ready = state != WRITE;
    assign take     = rx_valid && rx_ready;
    assign mem_we   = state == WRITE && !rst;
    assign last     = ({1'b0, mem_addr} + (ADDR_BITS+1)'(1)) >= count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: if (take && rx_data == SYNC_BYTE) begin
                    state   <= COUNT;
                    cpu_rst <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum    <= '0;
`endif
                end
                COUNT: if (take) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum <= csum ^ rx_data;
`endif
                    if (rx_data == 8'd0) begin
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                        state   <= IDLE;
                    end else if ({1'b0, rx_data} > 9'(DEPTH)) begin
                        error   <= 1'b1;
                        cpu_rst <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        count    <= (ADDR_BITS+1)'(rx_data);
                        mem_addr <= '0;
                        state    <= B0;
                    end
                end
                B0, B1, B2: if (take) begin
                    // Bytes arrive MSB first, so shifting left leaves {op, hi, lo}.
                    mem_wdata <= {mem_wdata[WORD_WIDTH-9:0], rx_data};
                    state     <= state == B2 ? WRITE : state + 3'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum      <= csum ^ rx_data;
`endif
                end
                WRITE: if (!last) begin
                    mem_addr <= mem_addr + 1'b1;
                    state    <= B0;
                end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state   <= CHECK;
`else
                    done    <= 1'b1;
                    cpu_rst <= 1'b0;
                    state   <= IDLE;
`endif
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHECK: if (take) begin
                    done    <= rx_data == csum;
                    error   <= rx_data != csum;
                    cpu_rst <= 1'b0;
                    state   <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames checked every cycle against a frame-level model of the loader.
module tb_prog_loader;
    typedef logic [7:0] bq_t[$];
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, mem_we, cpu_rst, done, error;
    logic [3:0]  mem_addr;
    logic [23:0] mem_wdata;

    prog_loader dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    int nw = 0, nd = 0, ne = 0;
    int wa[$], wd[$], wc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: tracks position in the frame, predicts next-cycle outputs.
    bit          e_we = 0, e_done = 0, e_err = 0, e_cpu = 0, e_ready = 1, e_wchk = 1;
    logic [3:0]  e_addr = 0;
    logic [23:0] e_wdata = 0, word = 0;
    logic [7:0]  sum = 0;
    bit          active = 0, have_n = 0, in_chk = 0, wr = 0;
    int          n = 0, widx = 0, nb = 0;

    task automatic finish_frame(input bit ok);
        active = 0;
        e_cpu  = 0;
        if (ok) e_done = 1; else e_err = 1;
    endtask

    always @(posedge clk) begin
        cyc++;
        e_done = 0;
        e_err  = 0;
        e_wchk = 0;
        if (rst) begin
            active = 0; wr = 0; e_we = 0; e_addr = 0; e_wdata = 0;
            e_cpu = 0; e_wchk = 1;
        end else if (wr) begin
            wr = 0;
            e_we = 0;
            widx++;
            if (widx < n) e_addr = 4'(widx);
            else if (EN) in_chk = 1;
            else finish_frame(1);
        end else if (rx_valid) begin
            if (!active) begin
                if (rx_data == 8'hA5) begin
                    active = 1; have_n = 0; in_chk = 0; sum = 0; nb = 0; e_cpu = 1;
                end
            end else if (!have_n) begin
                sum ^= rx_data;
                if (rx_data == 0) finish_frame(1);
                else if (rx_data > 16) finish_frame(0);
                else begin
                    n = rx_data; have_n = 1; widx = 0; e_addr = 0;
                end
            end else if (in_chk) begin
                in_chk = 0;
                finish_frame(rx_data == sum);
            end else begin
                sum ^= rx_data;
                word = {word[15:0], rx_data};
                nb++;
                if (nb == 3) begin
                    nb = 0; wr = 1; e_we = 1; e_wdata = word; e_wchk = 1;
                end
            end
        end
        e_ready = !wr;
    end

    always @(posedge clk) begin
        #1;
        check("rx_ready", rx_ready, e_ready);
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_addr);
        check("done", done, e_done);
        check("error", error, e_err);
        check("cpu_rst", cpu_rst, e_cpu);
        check("done_error_excl", done && error, 0);
        if (e_wchk) check("mem_wdata", mem_wdata, e_wdata);
        if (mem_we) begin
            nw++;
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
        if (done) nd++;
        if (error) ne++;
    end

    task automatic put(input logic [7:0] b);
        bit r;
        int g = 0;
        rx_data  = b;
        rx_valid = 1;
        do begin
            r = rx_ready;
            @(negedge clk);
            g++;
        end while (!r && g < 8);
        if (!r) begin
            fails++;
            $display("FAIL put_timeout: byte %0h not accepted in %0d cycles", b, g);
        end
    endtask

    task automatic raw(input bq_t q);
        foreach (q[i]) put(q[i]);
        rx_valid = 0;
    endtask

    task automatic frame(input bq_t q);
        logic [7:0] s = 0;
        for (int i = 1; i < q.size(); i++) s ^= q[i];
        if (EN) q.push_back(s);
        raw(q);
    endtask

    task automatic idle(input int c);
        rx_valid = 0;
        repeat (c) @(negedge clk);
    endtask

    int w0, d0, e0;
    bq_t b;

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        idle(2);

        w0 = nw; d0 = nd;
        b = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h05};
        frame(b);
        idle(3);
        check("t1_writes", nw - w0, 1);
        check("t1_addr", wa[w0], 0);
        check("t1_data", wd[w0], 24'h010005);
        check("t1_done", nd - d0, 1);

        w0 = nw; d0 = nd;
        b = '{8'hA5, 8'h02, 8'h10, 8'h12, 8'h34, 8'h20, 8'h00, 8'h03};
        frame(b);
        idle(3);
        check("t2_writes", nw - w0, 2);
        check("t2_addr0", wa[w0], 0);
        check("t2_data0", wd[w0], 24'h101234);
        check("t2_addr1", wa[w0+1], 1);
        check("t2_data1", wd[w0+1], 24'h200003);
        check("t2_spacing", wc[w0+1] - wc[w0], 4);
        check("t2_done", nd - d0, 1);

        w0 = nw; e0 = ne; d0 = nd;
        b = '{8'hA5, 8'h11};
        raw(b);
        idle(3);
        check("t3_error", ne - e0, 1);
        check("t3_writes", nw - w0, 0);
        check("t3_cpu_rst", cpu_rst, 0);
        b = '{8'hA5, 8'h01, 8'hAB, 8'hCD, 8'hEF};
        frame(b);
        idle(3);
        check("t3_reload_data", wd[w0], 24'hABCDEF);
        check("t3_reload_done", nd - d0, 1);

        w0 = nw; d0 = nd;
        b = '{8'h00, 8'hFF, 8'hA4, 8'hA5, 8'h00};
        raw(b);
        idle(3);
        check("t4_writes", nw - w0, 0);
        check("t4_done", nd - d0, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
        w0 = nw; d0 = nd; e0 = ne;
        b = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h05, 8'h06};
        raw(b);
        idle(3);
        check("t5_writes", nw - w0, 1);
        check("t5_error", ne - e0, 1);
        check("t5_no_done", nd - d0, 0);
`endif

        w0 = nw; d0 = nd;
        b = '{8'hA5, 8'h01, 8'h01, 8'h00};
        raw(b);
        rst = 1;
        @(negedge clk);
        rst = 0;
        idle(3);
        check("t6_no_write", nw - w0, 0);
        check("t6_no_done", nd - d0, 0);
        b = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h05};
        frame(b);
        idle(3);
        check("t6_resend_writes", nw - w0, 1);
        check("t6_resend_data", wd[w0], 24'h010005);
        check("t6_resend_done", nd - d0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
